game_io_regs: RTL and testbench

Parametrised processor-to-game I/O register bank that replaces the discrete per-register write strobes (game state, bird Y, score, sound) with one addressed write port. It has three parts:
- **Live registers**, written by the processor.
- **Committed display copies**, updated only on a frame-sync pulse so the renderer and seven-segment logic never see a half-updated frame.
- **Stretched sound-effect trigger pulses**, long enough to be sampled reliably from the slower audio clock domain.

It sits between the processor's I/O write outputs and the render, audio and display blocks.

---
 rtl/game_io_regs.sv | 115 +++++++++++
 tb/tb_game_io_regs.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/game_io_regs.sv
// game_io_regs: processor-to-game I/O register bank behind one addressed write port.
//   Live registers are written by the processor. Display copies latch the live values
//   only on frame_sync, so the renderer and seven-segment logic always see a whole
//   frame. Sound-effect triggers are stretched to STRETCH cycles so that the slower
//   audio clock domain can sample them reliably.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   wr_en/addr/data   write port; at SFX_ADDR, wr_data is the sound channel index
//   frame_sync        single-cycle commit request
//   live_regs         live values, register i at [i*DATA_W +: DATA_W]
//   disp_regs         committed copies, same packing
//   dirty             bit i: live[i] written since the last commit
//   commit_ack        one-cycle pulse after each commit
//   sfx_trig          stretched trigger per sound channel
//   addr_err          sticky flag: unmapped address or bad sound channel index
// Parameters must satisfy 2**ADDR_W > NUM_REGS, SFX_ADDR >= NUM_REGS, STRETCH >= 1.

// One sound channel: a down-counter that is reloaded on every trigger, which makes a
// retrigger restart the full pulse rather than extend the time that is left.
module game_io_sfx_stretch #(
  parameter int STRETCH = 8,
  parameter int CNT_W   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic trig
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)             cnt <= '0;
    else if (load)         cnt <= CNT_W'(STRETCH);
    else if (cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  assign trig = (cnt != '0);
endmodule

module game_io_regs #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 3,
  parameter int SFX_ADDR = 7,
  parameter int NUM_SFX  = 3,
  parameter int STRETCH  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       frame_sync,
  output logic [NUM_REGS*DATA_W-1:0] live_regs,
  output logic [NUM_REGS*DATA_W-1:0] disp_regs,
  output logic [NUM_REGS-1:0]        dirty,
  output logic                       commit_ack,
  output logic [NUM_SFX-1:0]         sfx_trig,
  output logic                       addr_err
);
  localparam int                CNT_W  = $clog2(STRETCH + 1);
  localparam logic [ADDR_W-1:0] NREG_A = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] SFX_A  = ADDR_W'(SFX_ADDR);
  localparam logic [DATA_W-1:0] NSFX_D = DATA_W'(NUM_SFX);

  logic [NUM_REGS-1:0][DATA_W-1:0] live_q, disp_q;
  logic [NUM_REGS-1:0]             dirty_q, wr_hit;
  logic                            commit_ack_q, addr_err_q;
  logic                            reg_wr, sfx_wr, sfx_ok, bad_wr;

  assign reg_wr = wr_en && (wr_addr < NREG_A);
  assign sfx_wr = wr_en && (wr_addr == SFX_A);
  assign sfx_ok = sfx_wr && (wr_data < NSFX_D);
  // Anything that is neither a register write nor a valid sound trigger is an error.
  assign bad_wr = wr_en && !reg_wr && !sfx_ok;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_hit
    assign wr_hit[i] = reg_wr && (wr_addr == ADDR_W'(i));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      live_q       <= '0;
      disp_q       <= '0;
      dirty_q      <= '0;
      commit_ack_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) live_q[i] <= wr_data;
        // A write landing in the commit cycle is forwarded, so it joins this frame.
        if (frame_sync) disp_q[i] <= wr_hit[i] ? wr_data : live_q[i];
      end
      // The commit clears dirty even for a coincident write, since that write was committed too.
      dirty_q      <= frame_sync ? '0 : (dirty_q | wr_hit);
      commit_ack_q <= frame_sync;
      addr_err_q   <= addr_err_q | bad_wr;
    end
  end

  for (genvar c = 0; c < NUM_SFX; c++) begin : g_sfx
    game_io_sfx_stretch #(.STRETCH(STRETCH), .CNT_W(CNT_W)) u_sfx (
      .clock (clock),
      .reset (reset),
      .load  (sfx_ok && (wr_data == DATA_W'(c))),
      .trig  (sfx_trig[c])
    );
  end

  assign live_regs  = live_q;
  assign disp_regs  = disp_q;
  assign dirty      = dirty_q;
  assign commit_ack = commit_ack_q;
  assign addr_err   = addr_err_q;
endmodule

// File: tb/tb_game_io_regs.sv
// Directed bench for game_io_regs with default parameters. Inputs change #1 after the
// rising edge, and outputs are sampled at that same point.
module tb_game_io_regs;
  logic         clock = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         frame_sync;
  logic [127:0] live_regs, disp_regs;
  logic [3:0]   dirty;
  logic         commit_ack;
  logic [2:0]   sfx_trig;
  logic         addr_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n, pre;

  game_io_regs dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_sync(frame_sync), .live_regs(live_regs), .disp_regs(disp_regs), .dirty(dirty),
    .commit_ack(commit_ack), .sfx_trig(sfx_trig), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; frame_sync = 1'b0;
  endtask

  // Single write held for one edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    idle();
  endtask

  // Number of consecutive samples, starting with the current one, that channel ch is high.
  task automatic measure(input int ch, output int cnt);
    cnt = 0;
    while (sfx_trig[ch] && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    // Reset wins over an active write and commit.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd5; frame_sync = 1'b1;
    repeat (3) step();
    chk("rst_live", live_regs, 128'h0);
    chk("rst_disp", disp_regs, 128'h0);
    chk("rst_dirty", dirty, 4'h0);
    chk("rst_ack", commit_ack, 1'b0);
    chk("rst_sfx", sfx_trig, 3'b000);
    chk("rst_err", addr_err, 1'b0);
    reset = 1'b0; idle();
    step();

    // Write, then commit four cycles later.
    wr(3'd1, 32'h64);
    chk("wr_live", live_regs[63:32], 32'h64);
    chk("wr_dirty", dirty, 4'b0010);
    chk("wr_disp", disp_regs, 128'h0);
    repeat (3) step();
    frame_sync = 1'b1; step(); idle();
    chk("cm_disp", disp_regs, {32'h0, 32'h0, 32'h64, 32'h0});
    chk("cm_dirty", dirty, 4'h0);
    chk("cm_ack", commit_ack, 1'b1);
    step();
    chk("cm_ack_off", commit_ack, 1'b0);

    // Write and commit in the same cycle: write is forwarded into disp.
    frame_sync = 1'b1; wr(3'd2, 32'hABC);
    chk("fw_disp", disp_regs, {32'h0, 32'hABC, 32'h64, 32'h0});
    chk("fw_live", live_regs, {32'h0, 32'hABC, 32'h64, 32'h0});
    chk("fw_dirty", dirty, 4'h0);
    chk("fw_ack", commit_ack, 1'b1);

    // Back-to-back commits keep commit_ack high; a write before them sets dirty first.
    wr(3'd3, 32'h77);
    chk("b2b_dirty", dirty, 4'b1000);
    frame_sync = 1'b1; step();
    chk("b2b_ack0", commit_ack, 1'b1);
    step(); idle();
    chk("b2b_ack1", commit_ack, 1'b1);
    chk("b2b_disp", disp_regs[127:96], 32'h77);
    step();
    chk("b2b_ack_off", commit_ack, 1'b0);

    // Single sound pulse on channel 1.
    wr(3'd7, 32'd1);
    chk("sfx_one", sfx_trig, 3'b010);
    measure(1, n);
    chk("sfx_len", n, 8);

    // Retrigger at cycle 5 of the pulse.
    wr(3'd7, 32'd1);
    pre = sfx_trig[1] ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (sfx_trig[1]) pre++;
    end
    wr(3'd7, 32'd1);
    measure(1, n);
    chk("sfx_retrig_len", pre + n, 13);

    // Channels 0 and 2 on consecutive cycles overlap independently.
    wr(3'd7, 32'd0);
    chk("ovl_n0", sfx_trig, 3'b001);
    wr(3'd7, 32'd2);
    chk("ovl_n1", sfx_trig, 3'b101);
    repeat (6) step();
    chk("ovl_n7", sfx_trig, 3'b101);
    step();
    chk("ovl_n8", sfx_trig, 3'b100);
    step();
    chk("ovl_n9", sfx_trig, 3'b000);

    // Unmapped write sets the sticky error and touches nothing else.
    chk("err_pre", addr_err, 1'b0);
    wr(3'd5, 32'h123);
    chk("err_unmapped", addr_err, 1'b1);
    chk("err_live", live_regs, {32'h77, 32'hABC, 32'h64, 32'h0});
    chk("err_disp", disp_regs, {32'h77, 32'hABC, 32'h64, 32'h0});
    wr(3'd7, 32'd3);
    chk("err_sfx_none", sfx_trig, 3'b000);
    repeat (3) step();
    chk("err_sticky", addr_err, 1'b1);

    // Reset three cycles into a pulse.
    wr(3'd7, 32'd1);
    step(); step();
    chk("mid_high", sfx_trig, 3'b010);
    reset = 1'b1; frame_sync = 1'b1; step();
    chk("mid_sfx", sfx_trig, 3'b000);
    chk("mid_err", addr_err, 1'b0);
    chk("mid_disp", disp_regs, 128'h0);
    chk("mid_ack", commit_ack, 1'b0);
    reset = 1'b0; idle(); step();
    chk("mid_ack2", commit_ack, 1'b0);
    wr(3'd7, 32'd1);
    measure(1, n);
    chk("post_rst_len", n, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
